// File: rtl/ser_queue_ctrl.sv
// Serial-in byte queue controller: synchronises async pins, assembles LSB-first words,
// arbitrates enqueue/dequeue strobes. Optional even-parity bit via `define PARITY_EN.
module ser_queue_ctrl #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned SYNC_STAGES = 2,
`ifdef PARITY_EN
    localparam int unsigned NBits      = DATA_W + 1,
`else
    localparam int unsigned NBits      = DATA_W,
`endif
    localparam int unsigned CntW       = $clog2(NBits + 1),
    localparam int unsigned TmoW       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic              clock_1MHz,
    input  logic              rst,
    input  logic              data_in,
    input  logic              write_in,
    input  logic              dequeue_in,
    input  logic              q_full,
    input  logic              q_empty,
    output logic              enq_o,
    output logic [DATA_W-1:0] enq_data_o,
    output logic              deq_o,
    output logic              status_out,
    output logic [CntW-1:0]   bit_cnt_o,
    output logic              timeout_o,
    output logic              err_o
);

    typedef enum logic [1:0] {StIdle, StShift, StCommit, StWaitSpace} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
    logic [SYNC_STAGES-1:0] dq_sync_q, dq_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   wr_prev_q, wr_prev_d, wr_edge_q, wr_edge_d;
    logic                   dq_prev_q, dq_prev_d, dq_edge_q, dq_edge_d;
    logic                   bit_q, bit_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [TmoW-1:0]        tmo_q, tmo_d, tmo_inc;
    logic                   pending_q, pending_d;
    logic                   status_q, status_d;
    logic                   timeout_q, timeout_d;
    logic                   par_err_q, par_err_d;
    logic                   is_par;

    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            wr_sync_q  <= '0;
            dq_sync_q  <= '0;
            dat_sync_q <= '0;
            wr_prev_q  <= 1'b0;
            wr_edge_q  <= 1'b0;
            dq_prev_q  <= 1'b0;
            dq_edge_q  <= 1'b0;
            bit_q      <= 1'b0;
            shift_q    <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            pending_q  <= 1'b0;
            status_q   <= 1'b0;
            timeout_q  <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_sync_q  <= wr_sync_d;
            dq_sync_q  <= dq_sync_d;
            dat_sync_q <= dat_sync_d;
            wr_prev_q  <= wr_prev_d;
            wr_edge_q  <= wr_edge_d;
            dq_prev_q  <= dq_prev_d;
            dq_edge_q  <= dq_edge_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            pending_q  <= pending_d;
            status_q   <= status_d;
            timeout_q  <= timeout_d;
            par_err_q  <= par_err_d;
        end
    end

    // Edge strobes are registered so the data bit lines up with them one cycle later.
    always_comb begin
        wr_sync_d  = {wr_sync_q[SYNC_STAGES-2:0], write_in};
        dq_sync_d  = {dq_sync_q[SYNC_STAGES-2:0], dequeue_in};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], data_in};
        wr_prev_d  = wr_sync_q[SYNC_STAGES-1];
        wr_edge_d  = wr_sync_q[SYNC_STAGES-1] & ~wr_prev_q;
        dq_prev_d  = dq_sync_q[SYNC_STAGES-1];
        dq_edge_d  = dq_sync_q[SYNC_STAGES-1] & ~dq_prev_q;
        bit_d      = dat_sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        timeout_d = 1'b0;
        par_err_d = 1'b0;
`ifdef PARITY_EN
        is_par    = (cnt_q == CntW'(DATA_W));
`else
        is_par    = 1'b0;
`endif
        tmo_inc   = (tmo_q == TmoW'(TIMEOUT_CYC)) ? tmo_q : tmo_q + TmoW'(1);
        unique case (state_q)
            StIdle: begin
                if (wr_edge_q && !q_full) begin
                    shift_d = {bit_q, {(DATA_W-1){1'b0}}};
                    cnt_d   = CntW'(1);
                    tmo_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (wr_edge_q) begin
                    cnt_d = cnt_q + CntW'(1);
                    tmo_d = '0;
                    if (!is_par) shift_d = {bit_q, shift_q[DATA_W-1:1]};
                    if (cnt_q == CntW'(NBits - 1)) begin
                        if (is_par && ((^shift_q) != bit_q)) begin
                            state_d   = StIdle;
                            cnt_d     = '0;
                            par_err_d = 1'b1;
                        end else begin
                            state_d = q_full ? StWaitSpace : StCommit;
                        end
                    end
                end else if (tmo_inc == TmoW'(TIMEOUT_CYC)) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    tmo_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            StCommit: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            StWaitSpace: begin
                if (!q_full) state_d = StCommit;
            end
            default: state_d = StIdle;
        endcase
        status_d  = (state_d == StIdle) && !q_full;
        // A new edge while a request is outstanding merges into it.
        pending_d = pending_q ? ~(deq_o | (pending_q & q_empty)) : dq_edge_q;
    end

    always_comb begin
        enq_o      = (state_q == StCommit);
        enq_data_o = shift_q;
        deq_o      = pending_q && !q_empty && !enq_o;
        err_o      = (pending_q && q_empty) || par_err_q;
        bit_cnt_o  = cnt_q;
        timeout_o  = timeout_q;
        status_out = status_q;
    end

endmodule
